// File: rtl/bullet_scheduler.sv
// bullet_scheduler: per-frame start/wait/release sequencer for N_SLOTS bullet units with a framebuffer write mux
// Optional BULLET_SCHED_STATS_EN adds saturating overrun_cnt / drop_cnt outputs.
module bullet_scheduler #(
    parameter int N_SLOTS = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 resetn,
`ifdef BULLET_SCHED_STATS_EN
    output logic [7:0]           overrun_cnt,
    output logic [7:0]           drop_cnt,
`endif
    input  logic                 frame_tick,
    input  logic                 shoot_req,
    input  logic [N_SLOTS-1:0]   slot_active,
    input  logic [N_SLOTS-1:0]   slot_done,
    input  logic [8*N_SLOTS-1:0] slot_x,
    input  logic [7*N_SLOTS-1:0] slot_y,
    input  logic [3*N_SLOTS-1:0] slot_color,
    input  logic [N_SLOTS-1:0]   slot_wren,
    output logic [N_SLOTS-1:0]   slot_start,
    output logic [N_SLOTS-1:0]   slot_shoot,
    output logic [7:0]           vga_x,
    output logic [6:0]           vga_y,
    output logic [2:0]           vga_color,
    output logic                 vga_wren,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 shoot_drop,
    output logic                 timeout_err
);
    localparam int IW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ARM, START, WAIT, REL, FIN} state_t;

    state_t          state, nxt;
    logic [IW-1:0]   idx, tgt, free_idx;
    logic [WW-1:0]   wdog;
    logic            shot_pend, tgt_valid, free_any, shot_eff, sel, done_sel, last;
    logic [7:0]      hx;
    logic [6:0]      hy;
    logic [2:0]      hc;
    logic [N_SLOTS-1:0] onehot;

    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!slot_active[i]) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    // a request arriving in the ARM cycle itself is served rather than lost
    assign shot_eff = shot_pend | shoot_req;
    assign sel      = (state == START) || (state == WAIT);
    assign done_sel = slot_done[idx];
    assign last     = (idx == IW'(N_SLOTS - 1));
    assign onehot   = N_SLOTS'(1) << idx;

    always_comb begin
        nxt = state;
        timeout_err = 1'b0;
        case (state)
            IDLE:  nxt = frame_tick ? ARM : IDLE;
            ARM:   nxt = START;
            START: nxt = WAIT;
            WAIT: begin
                if (done_sel || wdog == '0) nxt = REL;
                timeout_err = !done_sel && wdog == '0;
            end
            REL: begin
                if (!done_sel || wdog == '0) nxt = last ? FIN : START;
                timeout_err = done_sel && wdog == '0;
            end
            FIN:   nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            idx       <= '0;
            tgt       <= '0;
            tgt_valid <= 1'b0;
            shot_pend <= 1'b0;
            wdog      <= '0;
            hx        <= '0;
            hy        <= '0;
            hc        <= '0;
        end else begin
            state     <= nxt;
            shot_pend <= (state == ARM) ? 1'b0 : shot_eff;
            if (state == ARM) begin
                idx       <= '0;
                tgt       <= free_idx;
                tgt_valid <= shot_eff && free_any;
            end
            if (state == START)
                wdog <= WW'(TIMEOUT);
            else if (state == WAIT || state == REL)
                wdog <= (nxt != state) ? WW'(TIMEOUT) : wdog - WW'(1);
            if (state == REL && nxt == START)
                idx <= idx + IW'(1);
            if (state == FIN)
                tgt_valid <= 1'b0;
            if (sel) begin
                hx <= slot_x[8*idx +: 8];
                hy <= slot_y[7*idx +: 7];
                hc <= slot_color[3*idx +: 3];
            end
        end
    end

    assign slot_start = sel ? onehot : '0;
    assign slot_shoot = (sel && tgt_valid && tgt == idx) ? onehot : '0;
    assign vga_x      = sel ? slot_x[8*idx +: 8] : hx;
    assign vga_y      = sel ? slot_y[7*idx +: 7] : hy;
    assign vga_color  = sel ? slot_color[3*idx +: 3] : hc;
    assign vga_wren   = sel && slot_wren[idx];
    assign busy       = state != IDLE;
    assign frame_done = state == FIN;
    assign shoot_drop = (state == ARM) && shot_eff && !free_any;

`ifdef BULLET_SCHED_STATS_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overrun_cnt <= '0;
            drop_cnt    <= '0;
        end else begin
            overrun_cnt <= overrun_cnt + 8'(frame_tick && busy && overrun_cnt != 8'hff);
            drop_cnt    <= drop_cnt + 8'(shoot_drop && drop_cnt != 8'hff);
        end
    end
`endif
endmodule

// File: tb/tb_bullet_scheduler.sv
// tb_bullet_scheduler: directed bench for bullet_scheduler with a start/done slot responder
module tb_bullet_scheduler;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        frame_tick = 1'b0;
    logic        shoot_req = 1'b0;
    logic [3:0]  slot_active = 4'b0000;
    logic [3:0]  slot_done;
    logic [31:0] slot_x = {8'd40, 8'd77, 8'd20, 8'd10};
    logic [27:0] slot_y = {7'd4, 7'd33, 7'd2, 7'd1};
    logic [11:0] slot_color = {3'd3, 3'd5, 3'd2, 3'd1};
    logic [3:0]  slot_wren = 4'b0100;
    logic [3:0]  slot_start, slot_shoot;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_color;
    logic        vga_wren, busy, frame_done, shoot_drop, timeout_err;
`ifdef BULLET_SCHED_STATS_EN
    logic [7:0]  overrun_cnt, drop_cnt;
`endif

    bullet_scheduler #(.N_SLOTS(4), .TIMEOUT(15)) dut (
        .clk(clk), .resetn(resetn),
`ifdef BULLET_SCHED_STATS_EN
        .overrun_cnt(overrun_cnt), .drop_cnt(drop_cnt),
`endif
        .frame_tick(frame_tick), .shoot_req(shoot_req),
        .slot_active(slot_active), .slot_done(slot_done),
        .slot_x(slot_x), .slot_y(slot_y), .slot_color(slot_color), .slot_wren(slot_wren),
        .slot_start(slot_start), .slot_shoot(slot_shoot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .vga_wren(vga_wren),
        .busy(busy), .frame_done(frame_done), .shoot_drop(shoot_drop), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // slot model: done rises 2 cycles after start, falls with start; never[i] suppresses it
    logic [3:0] never = 4'b0000;
    logic [3:0] cnt [4] = '{default: 4'd0};
    always_ff @(posedge clk)
        for (int i = 0; i < 4; i++) cnt[i] <= slot_start[i] ? cnt[i] + 4'd1 : 4'd0;
    always_comb
        for (int i = 0; i < 4; i++) slot_done[i] = slot_start[i] && !never[i] && cnt[i] >= 4'd2;

    logic [7:0] xs [4] = '{8'd10, 8'd20, 8'd77, 8'd40};
    logic [6:0] ys [4] = '{7'd1, 7'd2, 7'd33, 7'd4};
    logic [2:0] cs [4] = '{3'd1, 3'd2, 3'd5, 3'd3};

    int total = 0, bad = 0;
    int n_starts, fd, drops, touts, bcyc, shoot_bad, multi, vga_bad;
    logic [3:0] starts [8];
    logic [3:0] shoot_seen, prev;

    task automatic run_pass(input int shoot_mode, input int extra_ticks);
        n_starts = 0; fd = 0; drops = 0; touts = 0; bcyc = 0;
        shoot_bad = 0; multi = 0; vga_bad = 0; shoot_seen = 0; prev = 0;
        for (int k = 0; k < 8; k++) starts[k] = 4'h0;
        if (shoot_mode == 1) begin
            shoot_req = 1'b1;
            @(negedge clk);
            shoot_req = 1'b0;
        end
        shoot_req = (shoot_mode == 2);
        frame_tick = 1'b1;
        @(negedge clk);
        shoot_req = 1'b0;
        frame_tick = 1'b0;
        for (int c = 0; c < 300 && !(fd > 0 && !busy); c++) begin
            if (busy) bcyc++;
            if (frame_done) fd++;
            if (shoot_drop) drops++;
            if (timeout_err) touts++;
            if (slot_start != 0 && slot_start != prev) begin
                if (n_starts < 8) starts[n_starts] = slot_start;
                n_starts++;
            end
            prev = slot_start;
            shoot_seen |= slot_shoot;
            if ((slot_shoot & ~slot_start) != 0) shoot_bad++;
            if (!$onehot0(slot_start)) multi++;
            if (slot_start == 0 && vga_wren) vga_bad++;
            for (int i = 0; i < 4; i++)
                if (slot_start == 4'(1 << i) &&
                    (vga_x !== xs[i] || vga_y !== ys[i] || vga_color !== cs[i] || vga_wren !== slot_wren[i]))
                    vga_bad++;
            frame_tick = (c >= 3 && c < 3 + extra_ticks);
            @(negedge clk);
        end
        frame_tick = 1'b0;
        total++;
        if (!(fd > 0 && !busy)) begin
            bad++;
            $display("FAIL pass_end: busy=%0b frame_done_count=%0d, required idle after one pass", busy, fd);
        end
    endtask

    task automatic test_reset;
        #2;
        total++; if (slot_start !== 4'h0) begin bad++; $display("FAIL rst_start: got %h want 0", slot_start); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if ({vga_wren, vga_x, frame_done, shoot_drop, timeout_err} !== 12'h0)
            begin bad++; $display("FAIL rst_outs: got %h want 0", {vga_wren, vga_x, frame_done, shoot_drop, timeout_err}); end
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sequence;
        run_pass(0, 0);
        total++; if (n_starts != 4) begin bad++; $display("FAIL seq_count: got %0d want 4", n_starts); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (starts[k] !== 4'(1 << k)) begin bad++; $display("FAIL seq_order%0d: got %h want %h", k, starts[k], 4'(1 << k)); end
        end
        total++; if (fd != 1) begin bad++; $display("FAIL seq_frame_done: got %0d want 1", fd); end
        total++; if (bcyc != 18) begin bad++; $display("FAIL seq_busy_len: got %0d want 18", bcyc); end
        total++; if (multi != 0) begin bad++; $display("FAIL seq_onehot: got %0d want 0", multi); end
        total++; if (vga_bad != 0) begin bad++; $display("FAIL seq_vga_mux: got %0d want 0", vga_bad); end
        total++; if (vga_x !== 8'd40 || vga_wren !== 1'b0) begin bad++; $display("FAIL seq_vga_hold: got x=%0d wren=%b want x=40 wren=0", vga_x, vga_wren); end
        total++; if (shoot_seen !== 4'h0) begin bad++; $display("FAIL seq_no_shoot: got %h want 0", shoot_seen); end
    endtask

    task automatic test_shoot;
        slot_active = 4'b0011;
        run_pass(1, 0);
        total++; if (shoot_seen !== 4'b0100) begin bad++; $display("FAIL shoot_slot2: got %h want 4", shoot_seen); end
        total++; if (shoot_bad != 0) begin bad++; $display("FAIL shoot_window: got %0d want 0", shoot_bad); end
        total++; if (drops != 0) begin bad++; $display("FAIL shoot_nodrop: got %0d want 0", drops); end
        slot_active = 4'b0101;
        run_pass(2, 0);
        total++; if (shoot_seen !== 4'b0010) begin bad++; $display("FAIL shoot_same_cycle: got %h want 2", shoot_seen); end
        run_pass(0, 0);
        total++; if (shoot_seen !== 4'b0000) begin bad++; $display("FAIL shoot_cleared: got %h want 0", shoot_seen); end
    endtask

    task automatic test_drop;
        slot_active = 4'b1111;
        run_pass(1, 0);
        total++; if (drops != 1) begin bad++; $display("FAIL drop_pulse: got %0d want 1", drops); end
        total++; if (shoot_seen !== 4'h0) begin bad++; $display("FAIL drop_no_shoot: got %h want 0", shoot_seen); end
`ifdef BULLET_SCHED_STATS_EN
        total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL drop_cnt: got %0d want 1", drop_cnt); end
`endif
        slot_active = 4'b0000;
    endtask

    task automatic test_timeout;
        never = 4'b0010;
        run_pass(0, 0);
        total++; if (touts != 1) begin bad++; $display("FAIL to_pulse: got %0d want 1", touts); end
        total++; if (n_starts != 4 || starts[3] !== 4'b1000) begin bad++; $display("FAIL to_continue: got n=%0d last=%h want 4/8", n_starts, starts[3]); end
        total++; if (bcyc != 32) begin bad++; $display("FAIL to_busy_len: got %0d want 32", bcyc); end
        never = 4'b0000;
    endtask

    task automatic test_reset_mid;
        never = 4'b0001;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk); @(negedge clk);
        total++; if (slot_start !== 4'b0001) begin bad++; $display("FAIL mid_in_wait: got %h want 1", slot_start); end
        #2 resetn = 1'b0;
        #1;
        total++; if (slot_start !== 4'h0 || busy !== 1'b0) begin bad++; $display("FAIL mid_async: got start=%h busy=%b want 0/0", slot_start, busy); end
        @(negedge clk);
        resetn = 1'b1;
        never = 4'b0000;
        @(negedge clk);
        run_pass(0, 3);
        total++; if (starts[0] !== 4'b0001 || n_starts != 4) begin bad++; $display("FAIL mid_restart: got first=%h n=%0d want 1/4", starts[0], n_starts); end
        total++; if (fd != 1) begin bad++; $display("FAIL overrun_ignored: got %0d want 1", fd); end
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL overrun_no_queue: got %b want 0", busy); end
`ifdef BULLET_SCHED_STATS_EN
        total++; if (overrun_cnt !== 8'd3) begin bad++; $display("FAIL overrun_cnt: got %0d want 3", overrun_cnt); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL drop_cnt_reset: got %0d want 0", drop_cnt); end
`endif
    endtask

    initial begin
        test_reset;
        test_sequence;
        test_shoot;
        test_drop;
        test_timeout;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
